// File: rtl/alu_result_fifo_pkg.sv
// Shared sizing constants for the ALU result path. The comparison stage,
// this FIFO and the writeback all import these values.
//   ALU_DATA_W     width of a sign-extended result word
//   ALU_FIFO_DEPTH entries in the result FIFO (power of two, >= 2)
//   ALU_FIFO_AW    log2(ALU_FIFO_DEPTH)
package alu_result_fifo_pkg;

  localparam int unsigned ALU_DATA_W     = 32;
  localparam int unsigned ALU_FIFO_DEPTH = 8;
  localparam int unsigned ALU_FIFO_AW    = 3;

endpackage

// File: rtl/alu_fifo_mem.sv
// Storage array for alu_result_fifo: DEPTH x (DATA_W+1) words, one
// synchronous write port and one asynchronous (combinational) read port.
// Contents are not reset.
//   clk    rising-edge clock
//   we     write enable
//   waddr  write address
//   wdata  write word {balance, result}
//   raddr  read address
//   rdata  read word at raddr (combinational)
module alu_fifo_mem
  import alu_result_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned DEPTH  = ALU_FIFO_DEPTH,
  parameter int unsigned ADDR_W = ALU_FIFO_AW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W:0]   wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W:0]   rdata
);

  logic [DATA_W:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Show-ahead FIFO buffering comparison-stage results for the ALU writeback.
// Each entry is a result word plus its balance (even-parity) flag. Also
// tracks how many held entries are balanced and a sticky overflow flag.
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        upstream result valid
//   in_result       result word (stored unmodified)
//   in_balance      balance flag for in_result
//   in_ready        FIFO can accept (not full)
//   out_valid       head entry available (not empty)
//   out_result      head result, 0 when empty
//   out_balance     head balance flag, 0 when empty
//   out_ready       consumer takes head this cycle
//   count           entries held, 0..DEPTH
//   balance_count   held entries with balance=1
//   overflow        sticky: in_valid seen while full
//   clear_ovf       synchronous clear of overflow
module alu_result_fifo
  import alu_result_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned DEPTH  = ALU_FIFO_DEPTH,
  parameter int unsigned ADDR_W = ALU_FIFO_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_balance,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic              out_balance,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W:0]   balance_count,
  output logic              overflow,
  input  logic              clear_ovf
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [DATA_W:0]   head;
  logic [ADDR_W:0]   bal_inc;
  logic [ADDR_W:0]   bal_dec;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  // A pop while full does not free a slot for the same-cycle push.
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;

  assign out_result  = empty ? '0 : head[DATA_W-1:0];
  assign out_balance = !empty && head[DATA_W];

  always_comb begin
    bal_inc = '0;
    bal_dec = '0;
    bal_inc[0] = push && in_balance;
    bal_dec[0] = pop && out_balance;
  end

  alu_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_balance, in_result}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Power-of-two depth: pointer increment wraps DEPTH-1 -> 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      balance_count <= '0;
      overflow      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      balance_count <= balance_count + bal_inc - bal_dec;
      if (in_valid && full) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_result;
  logic        in_balance;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_result;
  logic        out_balance;
  logic        out_ready;
  logic [3:0]  count;
  logic [3:0]  balance_count;
  logic        overflow;
  logic        clear_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_result_fifo dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_result     (in_result),
    .in_balance    (in_balance),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_result    (out_result),
    .out_balance   (out_balance),
    .out_ready     (out_ready),
    .count         (count),
    .balance_count (balance_count),
    .overflow      (overflow),
    .clear_ovf     (clear_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic b);
    in_valid   = 1'b1;
    in_result  = d;
    in_balance = b;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic pop_word();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_flags got=%b%b exp=01", out_valid, in_ready); end
    checks++; if (out_result !== 32'h0 || out_balance !== 1'b0) begin failures++; $display("FAIL rst_head got=%0h/%b exp=0/0", out_result, out_balance); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) push_word(32'h100 + i, 1'b1);
    checks++; if (count !== 4'd5 || balance_count !== 4'd5) begin failures++; $display("FAIL pre_rst_count got=%0d/%0d exp=5/5", count, balance_count); end
    // assert reset between edges; state must clear without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || balance_count !== 4'd0) begin failures++; $display("FAIL async_rst_count got=%0d/%0d exp=0/0", count, balance_count); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL async_rst_flags got=%b%b%b exp=010", out_valid, in_ready, overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_order();
    logic [31:0] d [3];
    logic        b [3];
    logic [3:0]  bc [3];
    d[0] = 32'h0000000C; b[0] = 1'b1; bc[0] = 4'd1;
    d[1] = 32'hFFFFFFF1; b[1] = 1'b0; bc[1] = 4'd1;
    d[2] = 32'h00000003; b[2] = 1'b1; bc[2] = 4'd0;
    for (int i = 0; i < 3; i++) push_word(d[i], b[i]);
    checks++; if (count !== 4'd3 || balance_count !== 4'd2) begin failures++; $display("FAIL order_fill got=%0d/%0d exp=3/2", count, balance_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_result !== d[i] || out_balance !== b[i]) begin failures++; $display("FAIL order_head%0d got=%0h/%b exp=%0h/%b", i, out_result, out_balance, d[i], b[i]); end
      pop_word();
      checks++; if (balance_count !== bc[i]) begin failures++; $display("FAIL order_bal%0d got=%0d exp=%0d", i, balance_count, bc[i]); end
    end
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL order_empty got=%0d/%b exp=0/0", count, out_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) push_word(32'hA0 + i, i[0]);
    checks++; if (count !== 4'd8 || in_ready !== 1'b0 || balance_count !== 4'd4) begin failures++; $display("FAIL full_state got=%0d/%b/%0d exp=8/0/4", count, in_ready, balance_count); end
    push_word(32'hDEAD, 1'b1);
    checks++; if (count !== 4'd8 || overflow !== 1'b1 || balance_count !== 4'd4) begin failures++; $display("FAIL full_drop got=%0d/%b/%0d exp=8/1/4", count, overflow, balance_count); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    in_valid = 1'b1; in_result = 32'hBEEF; clear_ovf = 1'b1;
    tick();
    in_valid = 1'b0; clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
    // pop while full: push still refused
    in_valid = 1'b1; in_result = 32'hCAFE; in_balance = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 4'd7 || balance_count !== 4'd4) begin failures++; $display("FAIL full_pop_push got=%0d/%0d exp=7/4", count, balance_count); end
    for (int i = 1; i < 8; i++) begin
      checks++; if (out_result !== 32'hA0 + i || out_balance !== i[0]) begin failures++; $display("FAIL full_drain%0d got=%0h/%b exp=%0h/%b", i, out_result, out_balance, 32'hA0 + i, i[0]); end
      pop_word();
    end
    checks++; if (count !== 4'd0 || balance_count !== 4'd0) begin failures++; $display("FAIL full_drained got=%0d/%0d exp=0/0", count, balance_count); end
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
  endtask

  task automatic test_concurrent();
    push_word(32'h10, 1'b0);
    push_word(32'h11, 1'b1);
    push_word(32'h12, 1'b1);
    push_word(32'h13, 1'b0);
    checks++; if (count !== 4'd4 || balance_count !== 4'd2) begin failures++; $display("FAIL conc_pre got=%0d/%0d exp=4/2", count, balance_count); end
    in_valid = 1'b1; in_result = 32'h14; in_balance = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 4'd4 || balance_count !== 4'd3) begin failures++; $display("FAIL conc_post got=%0d/%0d exp=4/3", count, balance_count); end
    for (int i = 1; i < 5; i++) begin
      checks++; if (out_result !== 32'h10 + i) begin failures++; $display("FAIL conc_drain%0d got=%0h exp=%0h", i, out_result, 32'h10 + i); end
      pop_word();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d;
    for (int i = 0; i < 20; i++) begin
      exp_d = 32'h5A000000 ^ (i * 32'h01010101);
      push_word(exp_d, i[0]);
      checks++; if (count !== 4'd1 || out_result !== exp_d || out_balance !== i[0]) begin failures++; $display("FAIL wrap%0d got=%0d/%0h/%b exp=1/%0h/%b", i, count, out_result, out_balance, exp_d, i[0]); end
      pop_word();
      checks++; if (count !== 4'd0 || balance_count !== 4'd0) begin failures++; $display("FAIL wrap_pop%0d got=%0d/%0d exp=0/0", i, count, balance_count); end
    end
  endtask

  task automatic test_empty();
    out_ready = 1'b1;
    tick();
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || balance_count !== 4'd0 || out_result !== 32'h0) begin failures++; $display("FAIL empty_pop got=%0d/%b/%0d/%0h exp=0/0/0/0", count, out_valid, balance_count, out_result); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_result = 32'h1F; in_balance = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_bypass got=%b exp=0", out_valid); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'h0000001F) begin failures++; $display("FAIL empty_push got=%b/%0h exp=1/1f", out_valid, out_result); end
    pop_word();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_balance = 1'b0;
    out_ready = 1'b0; clear_ovf = 1'b0;
    test_reset();
    test_order();
    test_full();
    test_concurrent();
    test_wrap();
    test_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
